// File: rtl/wordle_scorer.sv
// Sequential Wordle guess evaluator: a green pass then a yellow pass over five tiles,
// one tile per cycle, producing registered per-tile colour codes, a win flag and an invalid flag.
module wordle_scorer (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic [39:0] guess,
    input  logic [39:0] answer,
    output logic        ready,
    output logic        done,
    output logic [9:0]  colors,
    output logic        win,
    output logic        invalid
);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    localparam logic [1:0] TILE_GREY   = 2'b01;
    localparam logic [1:0] TILE_YELLOW = 2'b10;
    localparam logic [1:0] TILE_GREEN  = 2'b11;

    state_t      state;
    logic [2:0]  idx;
    logic [39:0] g_word;
    logic [39:0] a_word;
    logic [4:0]  green;
    logic [4:0]  used;
    logic [9:0]  tiles;

    logic [7:0]  g_cur;
    logic [7:0]  a_cur;
    logic [4:0]  claim;
    logic [1:0]  tile_code;
    logic [9:0]  tiles_next;
    logic        guess_bad;

    function automatic logic [7:0] get_byte(input logic [39:0] w, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = w[39:32];
            3'd1:    b = w[31:24];
            3'd2:    b = w[23:16];
            3'd3:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    assign g_cur = get_byte(g_word, idx);
    assign a_cur = get_byte(a_word, idx);

    // Lowest unclaimed answer position matching the current guess letter; the
    // descending scan lets the lowest index win.
    always_comb begin
        claim = 5'b0;
        for (int j = 4; j >= 0; j--) begin
            if (!used[j] && (get_byte(a_word, j[2:0]) == g_cur)) begin
                claim    = 5'b0;
                claim[j] = 1'b1;
            end
        end
    end

    always_comb begin
        if (green[idx])
            tile_code = TILE_GREEN;
        else if (claim != 5'b0)
            tile_code = TILE_YELLOW;
        else
            tile_code = TILE_GREY;
    end

    always_comb begin
        tiles_next = tiles;
        for (int k = 0; k < 5; k++) begin
            if (idx == k[2:0])
                tiles_next[9-2*k -: 2] = tile_code;
        end
    end

    always_comb begin
        guess_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!is_letter(get_byte(g_word, k[2:0])))
                guess_bad = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 3'd0;
            g_word  <= 40'd0;
            a_word  <= 40'd0;
            green   <= 5'd0;
            used    <= 5'd0;
            tiles   <= 10'd0;
            ready   <= 1'b1;
            done    <= 1'b0;
            colors  <= 10'd0;
            win     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        g_word <= guess;
                        a_word <= answer;
                        green  <= 5'd0;
                        used   <= 5'd0;
                        tiles  <= 10'd0;
                        idx    <= 3'd0;
                        ready  <= 1'b0;
                        state  <= GREEN;
                    end
                end
                GREEN: begin
                    if (g_cur == a_cur) begin
                        green[idx] <= 1'b1;
                        used[idx]  <= 1'b1;
                    end
                    if (idx == 3'd4) begin
                        idx   <= 3'd0;
                        state <= YELLOW;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                YELLOW: begin
                    tiles <= tiles_next;
                    if (!green[idx])
                        used <= used | claim;
                    if (idx == 3'd4) begin
                        idx   <= 3'd0;
                        state <= DONE;
                        done  <= 1'b1;
                        if (guess_bad) begin
                            colors  <= 10'h155;
                            win     <= 1'b0;
                            invalid <= 1'b1;
                        end else begin
                            colors  <= tiles_next;
                            win     <= (tiles_next == 10'h3FF);
                            invalid <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wordle_scorer.sv
// Directed bench for wordle_scorer: expected results are queued at start and
// compared when done pulses; latency, protocol and reset behaviour are also checked.
module tb_wordle_scorer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        ready;
    logic        done;
    logic [9:0]  colors;
    logic        win;
    logic        invalid;

    typedef struct packed {
        logic [9:0] colors;
        logic       win;
        logic       invalid;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 Clk = ~Clk;

    wordle_scorer dut (
        .Clk     (Clk),
        .reset   (reset),
        .start   (start),
        .guess   (guess),
        .answer  (answer),
        .ready   (ready),
        .done    (done),
        .colors  (colors),
        .win     (win),
        .invalid (invalid)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference scorer written from the game rules.
    function automatic exp_t model(input logic [39:0] a, input logic [39:0] g);
        logic [7:0] ab [5];
        logic [7:0] gb [5];
        logic [4:0] taken;
        logic [4:0] grn;
        exp_t       r;
        for (int k = 0; k < 5; k++) begin
            ab[k] = a[39-8*k -: 8];
            gb[k] = g[39-8*k -: 8];
        end
        r = '0;
        taken = '0;
        grn = '0;
        for (int k = 0; k < 5; k++) begin
            if (gb[k] < 8'h41 || gb[k] > 8'h5A) r.invalid = 1'b1;
            if (gb[k] == ab[k]) begin
                grn[k] = 1'b1;
                taken[k] = 1'b1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (grn[k]) begin
                r.colors[9-2*k -: 2] = 2'b11;
            end else begin
                r.colors[9-2*k -: 2] = 2'b01;
                for (int j = 0; j < 5; j++) begin
                    if (r.colors[9-2*k -: 2] == 2'b01 && !taken[j] && ab[j] == gb[k]) begin
                        taken[j] = 1'b1;
                        r.colors[9-2*k -: 2] = 2'b10;
                    end
                end
            end
        end
        r.win = (r.colors == 10'h3FF);
        if (r.invalid) begin
            r.colors = 10'h155;
            r.win = 1'b0;
        end
        return r;
    endfunction

    // Drive one start pulse; the inputs are scrambled right after capture.
    task automatic launch(input logic [39:0] a, input logic [39:0] g, input exp_t e);
        @(negedge Clk);
        answer = a;
        guess  = g;
        start  = 1'b1;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        start  = 1'b0;
        answer = ~a;
        guess  = ~g;
    endtask

    // Count edges until done is seen (sampled 1 time unit after each edge), bounded.
    task automatic wait_done(input bit pulse, output int edges);
        edges = 0;
        do begin
            @(posedge Clk);
            #1;
            edges++;
            if (pulse) start = (edges == 3 || edges == 6);
        end while (!done && edges < 40);
        if (pulse) start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_edges, input bit pulse);
        int   edges;
        exp_t e;
        wait_done(pulse, edges);
        chk({tag, "_latency"}, 16'(edges), 16'(exp_edges));
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_colors"},  16'(colors),  16'(e.colors));
            chk({tag, "_win"},     16'(win),     16'(e.win));
            chk({tag, "_invalid"}, 16'(invalid), 16'(e.invalid));
        end else begin
            chk({tag, "_done_seen"}, 16'(done), 16'd1);
        end
    endtask

    task automatic check_return(input string tag);
        @(posedge Clk);
        #1;
        chk({tag, "_done_width"}, 16'(done),  16'd0);
        chk({tag, "_ready_back"}, 16'(ready), 16'd1);
    endtask

    initial begin
        int   cnt;
        exp_t e;
        logic [39:0] ra;
        logic [39:0] rg;
        logic [7:0]  letters [3];
        letters[0] = 8'h41;
        letters[1] = 8'h42;
        letters[2] = 8'h45;

        reset  = 1'b1;
        start  = 1'b0;
        guess  = '0;
        answer = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_ready",   16'(ready),   16'd1);
        chk("rst_done",    16'(done),    16'd0);
        chk("rst_colors",  16'(colors),  16'd0);
        chk("rst_win",     16'(win),     16'd0);
        chk("rst_invalid", 16'(invalid), 16'd0);

        // done is observed in the cycle after edge N+10 (start sampled at edge N).
        launch("CRANE", "CRANE", '{10'h3FF, 1'b1, 1'b0});
        check_result("crane", 10, 1'b0);
        check_return("crane");

        launch("APPLE", "PAPAL", '{10'h2B6, 1'b0, 1'b0});
        check_result("papal", 10, 1'b0);
        check_return("papal");

        launch("CRANE", "EEEEE", '{10'h157, 1'b0, 1'b0});
        check_result("eeeee", 10, 1'b0);
        check_return("eeeee");

        launch("CRANE", "CR4NE", '{10'h155, 1'b0, 1'b1});
        check_result("cr4ne", 10, 1'b0);
        check_return("cr4ne");

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 5; k++) begin
                ra[39-8*k -: 8] = letters[$urandom_range(0, 2)];
                rg[39-8*k -: 8] = letters[$urandom_range(0, 2)];
            end
            launch(ra, rg, model(ra, rg));
            check_result($sformatf("rand%0d", n), 10, 1'b0);
            check_return($sformatf("rand%0d", n));
        end

        // Extra starts mid-evaluation must be ignored.
        launch("APPLE", "APPLE", '{10'h3FF, 1'b1, 1'b0});
        check_result("ignore", 10, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (done) cnt++;
        end
        chk("ignore_no_extra_done", 16'(cnt), 16'd0);

        // Start held high: two evaluations twelve cycles apart.
        @(negedge Clk);
        answer = "CRANE";
        guess  = "CRATE";
        e = model("CRANE", "CRATE");
        sb.push_back(e);
        sb.push_back(e);
        start = 1'b1;
        @(posedge Clk);
        #1;
        check_result("held_first", 10, 1'b0);
        check_result("held_period", 12, 1'b0);
        start = 1'b0;
        check_return("held");

        // Reset four cycles into a run: immediate return to reset values, no done.
        launch("CRANE", "CRANE", '{10'h3FF, 1'b1, 1'b0});
        repeat (4) @(posedge Clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ready",   16'(ready),   16'd1);
        chk("midrst_done",    16'(done),    16'd0);
        chk("midrst_colors",  16'(colors),  16'd0);
        chk("midrst_win",     16'(win),     16'd0);
        @(negedge Clk);
        reset = 1'b0;
        sb.delete();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (done) cnt++;
        end
        chk("midrst_no_done", 16'(cnt), 16'd0);
        chk("midrst_idle_ready", 16'(ready), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
